// File: rtl/strip_occupancy_tracker_pkg.sv
// Shared constants and FSM encoding for the strip occupancy tracker.
// Pure declarations: no latency, no handshake.
// Backpressure: n/a.
package strip_occupancy_tracker_pkg;

    localparam int STRIP_WIDTH = 128;
    localparam int OCC_W       = 8;
    localparam int PROG_W      = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        CHECK = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/strip_occupancy_tracker_if.sv
// Request, strike-detector and response signals of the strip occupancy tracker.
// Wires only: no latency.
// Backpressure: req_valid/req_ready, the source holds the request until req_ready.
interface strip_occupancy_tracker_if #(
    parameter int IDX_W = 4
);
    import strip_occupancy_tracker_pkg::*;

    logic              clear;
    logic              req_valid;
    logic              req_ready;
    logic [PROG_W-1:0] width_in;
    logic [OCC_W-1:0]  min_occupied_strip_width;
    logic [PROG_W-1:0] det_width;
    logic              strike_flag;
    logic [OCC_W-1:0]  new_occupied_strip_width;
    logic              resp_valid;
    logic [IDX_W-1:0]  resp_strip_idx;
    logic [OCC_W-1:0]  resp_x;
    logic              resp_strike;

    modport slave (
        input  clear, req_valid, width_in, strike_flag, new_occupied_strip_width,
        output req_ready, min_occupied_strip_width, det_width,
               resp_valid, resp_strip_idx, resp_x, resp_strike
    );

    modport master (
        output clear, req_valid, width_in, strike_flag, new_occupied_strip_width,
        input  req_ready, min_occupied_strip_width, det_width,
               resp_valid, resp_strip_idx, resp_x, resp_strike
    );

endinterface

// File: rtl/strip_occupancy_tracker_strip_min_scanner.sv
// Sequential search for the least-occupied strip, lowest index wins ties.
// Latency: NUM_STRIPS-1 cycles after start, done high in the last compare cycle.
// Backpressure: none; start is only issued while idle.
module strip_min_scanner #(
    parameter int NUM_STRIPS = 16,
    parameter int IDX_W      = 4
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic                                           start,
    output logic                                           done,
    output logic [IDX_W-1:0]                               rd_idx,
    input  logic [strip_occupancy_tracker_pkg::OCC_W-1:0]  rd_dat,
    output logic [IDX_W-1:0]                               best_idx,
    output logic [strip_occupancy_tracker_pkg::OCC_W-1:0]  best_w
);
    import strip_occupancy_tracker_pkg::*;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STRIPS - 1);

    logic             busy;
    logic [IDX_W-1:0] scan_idx;

    // While idle the read port points at strip 0 so start can seed best_w.
    assign rd_idx = busy ? scan_idx : '0;
    assign done   = busy && (scan_idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            scan_idx <= '0;
            best_idx <= '0;
            best_w   <= '0;
        end else if (start) begin
            busy     <= 1'b1;
            scan_idx <= IDX_W'(1);
            best_idx <= '0;
            best_w   <= rd_dat;
        end else if (busy) begin
            if (rd_dat < best_w) begin
                best_idx <= scan_idx;
                best_w   <= rd_dat;
            end
            if (done) begin
                busy <= 1'b0;
            end else begin
                scan_idx <= scan_idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/strip_occupancy_tracker.sv
// Tracks per-strip occupancy and places one request at a time on the least-occupied strip.
// Latency: NUM_STRIPS+1 cycles from accept to resp_valid; one request per NUM_STRIPS+2 cycles.
// Backpressure: req_ready only in IDLE. Optional STRIKE_COUNT_EN adds strike_count/strike_any.
module strip_occupancy_tracker #(
    parameter int NUM_STRIPS  = 16,
    parameter int IDX_W       = 4,
    parameter int STRIP_WIDTH = strip_occupancy_tracker_pkg::STRIP_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    strip_occupancy_tracker_if.slave bus
`ifdef STRIKE_COUNT_EN
    ,
    output logic [7:0]               strike_count,
    output logic                     strike_any
`endif
);
    import strip_occupancy_tracker_pkg::*;

    localparam logic [OCC_W:0] STRIP_LIMIT = (OCC_W + 1)'(STRIP_WIDTH);

    state_t            state;
    state_t            state_nxt;
    logic              scan_start;
    logic              scan_done;
    logic              accept_clear;
    logic              commit;
    logic [IDX_W-1:0]  rd_idx;
    logic [IDX_W-1:0]  best_idx;
    logic [OCC_W-1:0]  best_w;
    logic [OCC_W-1:0]  occ [NUM_STRIPS];
    logic [PROG_W-1:0] det_width_q;
    logic              resp_valid_q;
    logic [IDX_W-1:0]  resp_idx_q;
    logic [OCC_W-1:0]  resp_x_q;
    logic              resp_strike_q;

    strip_min_scanner #(
        .NUM_STRIPS (NUM_STRIPS),
        .IDX_W      (IDX_W)
    ) u_scanner (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (scan_start),
        .done     (scan_done),
        .rd_idx   (rd_idx),
        .rd_dat   (occ[rd_idx]),
        .best_idx (best_idx),
        .best_w   (best_w)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // clear wins over a simultaneous request; the request stays pending at the source.
    always_comb begin
        state_nxt  = state;
        scan_start = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_valid && !bus.clear) begin
                    scan_start = 1'b1;
                    state_nxt  = SCAN;
                end
            end
            SCAN: begin
                if (scan_done) begin
                    state_nxt = CHECK;
                end
            end
            CHECK:   state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign accept_clear = (state == IDLE) && bus.clear;
    assign commit       = (state == CHECK) && !bus.strike_flag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_STRIPS; i++) begin
                occ[i] <= '0;
            end
        end else if (accept_clear) begin
            for (int i = 0; i < NUM_STRIPS; i++) begin
                occ[i] <= '0;
            end
        end else if (commit) begin
            occ[best_idx] <= bus.new_occupied_strip_width;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            det_width_q   <= '0;
            resp_valid_q  <= 1'b0;
            resp_idx_q    <= '0;
            resp_x_q      <= '0;
            resp_strike_q <= 1'b0;
        end else begin
            resp_valid_q <= (state == CHECK);
            if (scan_start) begin
                det_width_q <= bus.width_in;
            end
            if (state == CHECK) begin
                resp_idx_q    <= best_idx;
                resp_x_q      <= best_w;
                resp_strike_q <= bus.strike_flag;
            end
        end
    end

    // Gating with rst_n keeps req_ready low while reset is held even though state reads IDLE.
    assign bus.req_ready                = rst_n && (state == IDLE);
    assign bus.min_occupied_strip_width = best_w;
    assign bus.det_width                = det_width_q;
    assign bus.resp_valid               = resp_valid_q;
    assign bus.resp_strip_idx           = resp_idx_q;
    assign bus.resp_x                   = resp_x_q;
    assign bus.resp_strike              = resp_strike_q;

`ifdef STRIKE_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strike_count <= '0;
        end else if (accept_clear) begin
            strike_count <= '0;
        end else if ((state == CHECK) && bus.strike_flag && (strike_count != 8'hFF)) begin
            strike_count <= strike_count + 8'd1;
        end
    end

    assign strike_any = (strike_count != 8'd0);
`endif

    commit_within_strip: assert property (@(posedge clk) disable iff (!rst_n)
        commit |-> ({1'b0, bus.new_occupied_strip_width} <= STRIP_LIMIT));

endmodule

// File: tb/tb_strip_occupancy_tracker.sv
// Directed bench for strip_occupancy_tracker with a behavioural strike detector.
// Build with +define+STRIKE_COUNT_EN to also exercise the strike counter.
module tb_strip_occupancy_tracker;
    import strip_occupancy_tracker_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;
    int   n_fail;

    strip_occupancy_tracker_if #(.IDX_W(4)) bus ();

`ifdef STRIKE_COUNT_EN
    logic [7:0] strike_count;
    logic       strike_any;
`endif

    strip_occupancy_tracker #(
        .NUM_STRIPS (16),
        .IDX_W      (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef STRIKE_COUNT_EN
        ,
        .strike_count (strike_count),
        .strike_any   (strike_any)
`endif
    );

    // Strike detector: candidate = occupied + program width, strike above the strip width.
    logic [8:0] det_sum;
    assign det_sum                      = 9'(bus.min_occupied_strip_width) + 9'(bus.det_width);
    assign bus.strike_flag              = det_sum > 9'(STRIP_WIDTH);
    assign bus.new_occupied_strip_width = det_sum[7:0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issues one request and checks latency plus the response fields.
    task automatic do_req(input logic [4:0] w, input int e_idx, input int e_x,
                          input logic e_strike, input string tag);
        int lat;
        bit got;
        @(negedge clk);
        check($sformatf("%s_ready", tag), 32'(bus.req_ready), 1);
        bus.req_valid = 1'b1;
        bus.width_in  = w;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.width_in  = 5'd0;
        check($sformatf("%s_busy", tag), 32'(bus.req_ready), 0);
        check($sformatf("%s_det", tag), 32'(bus.det_width), 32'(w));
        lat = 1;
        got = 1'b0;
        while (!got && lat < 40) begin
            if (bus.resp_valid) begin
                got = 1'b1;
            end else begin
                @(negedge clk);
                lat++;
            end
        end
        check($sformatf("%s_gotresp", tag), 32'(got), 1);
        check($sformatf("%s_lat", tag), 32'(lat), 17);
        check($sformatf("%s_idx", tag), 32'(bus.resp_strip_idx), 32'(e_idx));
        check($sformatf("%s_x", tag), 32'(bus.resp_x), 32'(e_x));
        check($sformatf("%s_strike", tag), 32'(bus.resp_strike), 32'(e_strike));
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
    endtask

    initial begin
        int seen;
        int sum;
        n_checks = 0;
        n_pass   = 0;
        n_fail   = 0;
        rst_n         = 1'b0;
        bus.clear     = 1'b0;
        bus.req_valid = 1'b0;
        bus.width_in  = 5'd0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(bus.req_ready), 0);
        check("rst_outputs", 32'({bus.resp_valid, bus.resp_strike, bus.resp_strip_idx,
                                  bus.resp_x, bus.det_width, bus.min_occupied_strip_width}), 0);
        rst_n = 1'b1;
        #1;
        check("ready_after_rst", 32'(bus.req_ready), 1);

        // First placement lands on strip 0 at x 0
        do_req(5'd10, 0, 0, 1'b0, "first");
        check("first_occ0", 32'(dut.occ[0]), 10);

        // clear together with req_valid: occupancy zeroed, request not taken
        @(negedge clk);
        bus.clear     = 1'b1;
        bus.req_valid = 1'b1;
        bus.width_in  = 5'd5;
        @(negedge clk);
        check("clr_ready", 32'(bus.req_ready), 1);
        check("clr_det_kept", 32'(bus.det_width), 10);
        check("clr_occ0", 32'(dut.occ[0]), 0);
        bus.clear     = 1'b0;
        bus.req_valid = 1'b0;
        bus.width_in  = 5'd0;
        repeat (3) @(negedge clk);
        check("clr_no_resp", 32'(bus.resp_valid), 0);
        check("clr_still_idle", 32'(bus.req_ready), 1);

        // 16 equal requests fill strips in order; the 17th wraps to strip 0
        for (int i = 0; i < 16; i++) begin
            do_req(5'd8, i, 0, 1'b0, $sformatf("fill8_%0d", i));
        end
        do_req(5'd8, 0, 8, 1'b0, "fill8_wrap");

        // Unequal occupancy: strip 5 at 3, all others at 4
        pulse_clear();
        for (int i = 0; i < 16; i++) begin
            do_req((i == 5) ? 5'd3 : 5'd4, i, 0, 1'b0, $sformatf("uneq_%0d", i));
        end
        do_req(5'd31, 5, 3, 1'b0, "uneq_min");
        check("uneq_occ5", 32'(dut.occ[5]), 34);

        // Bring every strip to 120, then to exactly 128
        pulse_clear();
        for (int i = 0; i < 64; i++) begin
            do_req(5'd30, i % 16, (i / 16) * 30, 1'b0, $sformatf("to120_%0d", i));
        end
        for (int i = 0; i < 16; i++) begin
            do_req(5'd8, i, 120, 1'b0, $sformatf("to128_%0d", i));
        end
        check("full_occ0", 32'(dut.occ[0]), 128);
        check("full_occ15", 32'(dut.occ[15]), 128);

        // All strips full: strike on lowest index, nothing committed
        do_req(5'd1, 0, 128, 1'b1, "strike1");
        check("strike1_occ0", 32'(dut.occ[0]), 128);
`ifdef STRIKE_COUNT_EN
        check("strike_count1", 32'(strike_count), 1);
        check("strike_any1", 32'(strike_any), 1);
`endif
        do_req(5'd0, 0, 128, 1'b0, "zero_w");
        check("zero_w_occ0", 32'(dut.occ[0]), 128);
        do_req(5'd31, 0, 128, 1'b1, "strike31");
        check("strike31_occ0", 32'(dut.occ[0]), 128);
`ifdef STRIKE_COUNT_EN
        check("strike_count2", 32'(strike_count), 2);
`endif

        pulse_clear();
`ifdef STRIKE_COUNT_EN
        check("strike_count_clr", 32'(strike_count), 0);
        check("strike_any_clr", 32'(strike_any), 0);
`endif
        do_req(5'd7, 0, 0, 1'b0, "pre_rst");

        // Reset mid-SCAN aborts the request with no response
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.width_in  = 5'd9;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.width_in  = 5'd0;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            seen += int'(bus.resp_valid);
        end
        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen += int'(bus.resp_valid);
        end
        check("midrst_ready_low", 32'(bus.req_ready), 0);
        rst_n = 1'b1;
        #1;
        check("midrst_ready_high", 32'(bus.req_ready), 1);
        repeat (25) begin
            @(negedge clk);
            seen += int'(bus.resp_valid);
        end
        check("midrst_no_resp", 32'(seen), 0);
        check("midrst_idle", 32'(bus.req_ready), 1);
        sum = 0;
        for (int i = 0; i < 16; i++) begin
            sum += int'(dut.occ[i]);
        end
        check("midrst_occ_zero", 32'(sum), 0);
        do_req(5'd6, 0, 0, 1'b0, "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
